// File: rtl/ram_bist_ctrl.sv
// March-less RAM BIST: one write pass then one read/compare pass over the whole array.
// Optional macro RAM_BIST_ERR_INJECT_EN adds err_inject, which flips bit 0 of the address-0 write.
module ram_bist_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              loop,
`ifdef RAM_BIST_ERR_INJECT_EN
   input  logic              err_inject,
`endif
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
   localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

   function automatic logic [DATA_W-1:0] pattern_f(input logic [1:0] sel,
                                                   input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] p;
      p = {DATA_W{1'b0}};
      case (sel)
         2'd0: p = DATA_W'(addr);
         2'd1: p = DATA_W'(1'b1) << (32'(addr) % DATA_W);
         2'd2: for (int i = 0; i < DATA_W; i++) p[i] = i[0] ^ addr[0];
         2'd3: p = ~DATA_W'(addr);
         default: p = {DATA_W{1'b0}};
      endcase
      return p;
   endfunction

   state_t              state_r, state_s;
   logic [ADDR_W-1:0]   cnt_r, cnt_s;
   logic [1:0]          drain_r, drain_s;
   logic [1:0]          mode_r;
   logic                inj_r;
   logic                inj_bit_s;
   logic [DATA_W-1:0]   wr_data_s;

   logic                ram_en_r, ram_we_r, busy_r, done_r, pass_r;
   logic [ADDR_W-1:0]   ram_addr_r, first_err_r, first_err_s;
   logic [DATA_W-1:0]   ram_wr_data_r;
   logic [15:0]         err_cnt_r, err_cnt_s;

   logic                exp_v_r [RD_LAT];
   logic [DATA_W-1:0]   exp_d_r [RD_LAT];
   logic [ADDR_W-1:0]   exp_a_r [RD_LAT];
   logic                mismatch_s;
   logic                run_clear_s;

   // Phase state, address/drain counters, and per-run configuration latched at start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         cnt_r   <= '0;
         drain_r <= 2'd0;
         mode_r  <= 2'd0;
         inj_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         drain_r <= drain_s;
         if (state_r == S_IDLE && start) begin
            mode_r <= mode;
`ifdef RAM_BIST_ERR_INJECT_EN
            inj_r  <= err_inject;
`else
            inj_r  <= 1'b0;
`endif
         end else begin
            mode_r <= mode_r;
            inj_r  <= inj_r;
         end
      end
   end

   // Next-state and counter sequencing
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      drain_s = drain_r;
      case (state_r)
         S_IDLE: begin
            cnt_s   = '0;
            drain_s = 2'd0;
            if (start) state_s = S_WRITE;
            else       state_s = S_IDLE;
         end
         S_WRITE: begin
            if (cnt_r == LAST_ADDR) begin
               state_s = S_READ;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + ADDR_W'(1'b1);
            end
         end
         S_READ: begin
            if (cnt_r == LAST_ADDR) begin
               state_s = S_DRAIN;
               cnt_s   = '0;
            end else begin
               cnt_s   = cnt_r + ADDR_W'(1'b1);
            end
         end
         S_DRAIN: begin
            if (drain_r == LAT_LAST) begin
               state_s = S_DONE;
               drain_s = 2'd0;
            end else begin
               drain_s = drain_r + 2'd1;
            end
         end
         S_DONE: begin
            cnt_s = '0;
            if (loop) state_s = S_WRITE;
            else      state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
            cnt_s   = '0;
            drain_s = 2'd0;
         end
      endcase
   end

   assign inj_bit_s   = inj_r & (cnt_r == '0);
   assign wr_data_s   = pattern_f(mode_r, cnt_r) ^ {{(DATA_W-1){1'b0}}, inj_bit_s};
   assign run_clear_s = (state_r == S_WRITE) && (cnt_r == '0);

   // RAM-side and handshake outputs, registered one cycle behind the phase state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_en_r      <= 1'b0;
         ram_we_r      <= 1'b0;
         ram_addr_r    <= '0;
         ram_wr_data_r <= '0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         ram_en_r      <= (state_r == S_WRITE) || (state_r == S_READ);
         ram_we_r      <= (state_r == S_WRITE);
         ram_addr_r    <= ((state_r == S_WRITE) || (state_r == S_READ)) ? cnt_r : '0;
         ram_wr_data_r <= (state_r == S_WRITE) ? wr_data_s : '0;
         busy_r        <= (state_r != S_IDLE);
         done_r        <= (state_r == S_DONE);
      end
   end

   // Expected data follows the read address through the same latency as the RAM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) begin
            exp_v_r[i] <= 1'b0;
            exp_d_r[i] <= '0;
            exp_a_r[i] <= '0;
         end
      end else begin
         exp_v_r[0] <= ram_en_r & ~ram_we_r;
         exp_d_r[0] <= pattern_f(mode_r, ram_addr_r);
         exp_a_r[0] <= ram_addr_r;
         for (int i = 1; i < RD_LAT; i++) begin
            exp_v_r[i] <= exp_v_r[i-1];
            exp_d_r[i] <= exp_d_r[i-1];
            exp_a_r[i] <= exp_a_r[i-1];
         end
      end
   end

   assign mismatch_s = exp_v_r[RD_LAT-1] && (ram_rd_data != exp_d_r[RD_LAT-1]);

   // Error accounting; a fresh run wipes the previous run's results
   always_comb begin
      err_cnt_s   = err_cnt_r;
      first_err_s = first_err_r;
      if (run_clear_s) begin
         err_cnt_s   = 16'd0;
         first_err_s = '0;
      end else if (mismatch_s) begin
         if (err_cnt_r != 16'hFFFF) err_cnt_s = err_cnt_r + 16'd1;
         else                       err_cnt_s = err_cnt_r;
         if (err_cnt_r == 16'd0) first_err_s = exp_a_r[RD_LAT-1];
         else                    first_err_s = first_err_r;
      end else begin
         err_cnt_s   = err_cnt_r;
         first_err_s = first_err_r;
      end
   end

   // Result registers; pass is judged on the count including the final compare
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r   <= 16'd0;
         first_err_r <= '0;
         pass_r      <= 1'b0;
      end else begin
         err_cnt_r   <= err_cnt_s;
         first_err_r <= first_err_s;
         if (run_clear_s)              pass_r <= 1'b0;
         else if (state_r == S_DONE)   pass_r <= (err_cnt_s == 16'd0);
         else                          pass_r <= pass_r;
      end
   end

   assign ram_en         = ram_en_r;
   assign ram_we         = ram_we_r;
   assign ram_addr       = ram_addr_r;
   assign ram_wr_data    = ram_wr_data_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign err_cnt        = err_cnt_r;
   assign first_err_addr = first_err_r;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: stimulus queues expected writes and run results,
// monitors pop and compare as the DUT writes and pulses done.
module tb_ram_bist_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       loop = 1'b0;
`ifdef RAM_BIST_ERR_INJECT_EN
   logic       err_inject = 1'b0;
`endif
   logic       ram_en, ram_we, busy, done, pass;
   logic [4:0] ram_addr, first_err_addr;
   logic [7:0] ram_wr_data;
   logic [7:0] ram_rd_data = 8'h00;
   logic [15:0] err_cnt;

   ram_bist_ctrl #(.DATA_W(8), .ADDR_W(5), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .loop(loop),
`ifdef RAM_BIST_ERR_INJECT_EN
      .err_inject(err_inject),
`endif
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; } wr_t;
   typedef struct { int cyc; int err; int first; int pass; } res_t;

   wr_t  wq[$];
   res_t rq[$];
   wr_t  mon_w;
   res_t mon_r;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic [7:0] mem [32];
   bit   corrupt7 = 1'b0;
   bit   stuck3 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model, one-cycle read latency, with optional read-side faults
   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wr_data;
      if (ram_en && !ram_we)
         ram_rd_data <= (corrupt7 && ram_addr == 5'd7) ? 8'h00
                        : (mem[ram_addr] & (stuck3 ? 8'hF7 : 8'hFF));
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int exp_wr(input logic [1:0] m, input int a);
      logic [7:0] av, one;
      av  = 8'(a);
      one = 8'h01;
      case (m)
         2'd0:    return int'(av);
         2'd1:    return int'(8'(one << (a % 8)));
         2'd2:    return av[0] ? 32'h55 : 32'hAA;
         default: return int'(8'(~av));
      endcase
   endfunction

   // Write monitor
   always @(negedge clk) begin
      if (ram_en && ram_we) begin
         if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%0d data=%0d", ram_addr, ram_wr_data);
         end else begin
            mon_w = wq.pop_front();
            chk("wr_addr", int'(ram_addr), mon_w.addr);
            chk("wr_data", int'(ram_wr_data), mon_w.data);
         end
      end
   end

   // Done monitor
   always @(negedge clk) begin
      if (done) begin
         if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done cycle=%0d", cyc);
         end else begin
            mon_r = rq.pop_front();
            chk("done_cycle", cyc, mon_r.cyc);
            chk("err_cnt", int'(err_cnt), mon_r.err);
            chk("first_err_addr", int'(first_err_addr), mon_r.first);
            chk("pass", int'(pass), mon_r.pass);
            chk("busy_at_done", int'(busy), 1);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ram_en"}, int'(ram_en), 0);
      chk({tag, "_ram_we"}, int'(ram_we), 0);
      chk({tag, "_ram_addr"}, int'(ram_addr), 0);
      chk({tag, "_ram_wr_data"}, int'(ram_wr_data), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_pass"}, int'(pass), 0);
      chk({tag, "_err_cnt"}, int'(err_cnt), 0);
      chk({tag, "_first_err_addr"}, int'(first_err_addr), 0);
   endtask

   task automatic push_writes(input logic [1:0] m, input bit inj);
      wr_t w;
      for (int a = 0; a < 32; a++) begin
         w.addr = a;
         w.data = exp_wr(m, a);
         if (inj && a == 0) w.data = w.data ^ 1;
         wq.push_back(w);
      end
   endtask

   task automatic run_test(input logic [1:0] m, input bit lp, input bit inj, input int nruns,
                           input int e_err, input int e_first, input int e_pass);
      int   t0;
      res_t r;
      @(negedge clk);
      t0 = cyc;
      for (int k = 0; k < nruns; k++) begin
         r.cyc = t0 + 67 + 66 * k;
         r.err = e_err;
         r.first = e_first;
         r.pass = e_pass;
         rq.push_back(r);
         push_writes(m, inj);
      end
      start = 1'b1;
      mode  = m;
      loop  = lp;
`ifdef RAM_BIST_ERR_INJECT_EN
      err_inject = inj;
`endif
      @(negedge clk);
      start = 1'b0;
      mode  = ~m;
`ifdef RAM_BIST_ERR_INJECT_EN
      err_inject = 1'b0;
`endif
      if (lp) begin
         repeat (98) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (50) @(negedge clk);
         loop = 1'b0;
      end
      for (int i = 0; i < 500 && rq.size() != 0; i++) @(negedge clk);
      if (rq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout pending=%0d required=0", rq.size());
         rq.delete();
         wq.delete();
      end
      repeat (4) @(negedge clk);
      chk("busy_idle", int'(busy), 0);
      chk("pass_hold", int'(pass), e_pass);
      chk("wq_drained", wq.size(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst_active");
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("rst_release");

      run_test(2'd0, 1'b0, 1'b0, 1, 0, 0, 1);
      corrupt7 = 1'b1;
      run_test(2'd2, 1'b0, 1'b0, 1, 1, 7, 0);
      corrupt7 = 1'b0;
      stuck3 = 1'b1;
      run_test(2'd1, 1'b0, 1'b0, 1, 4, 3, 0);
      stuck3 = 1'b0;
      run_test(2'd3, 1'b0, 1'b0, 1, 0, 0, 1);

      // Abort a failing run mid-read with reset
      stuck3 = 1'b1;
      @(negedge clk);
      push_writes(2'd1, 1'b0);
      start = 1'b1;
      mode  = 2'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      chk("abort_err_before_rst", int'(err_cnt), 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("abort");
      chk("abort_wq", wq.size(), 0);
      rst = 1'b0;
      stuck3 = 1'b0;
      repeat (3) @(negedge clk);
      run_test(2'd0, 1'b0, 1'b0, 1, 0, 0, 1);

      corrupt7 = 1'b1;
      run_test(2'd2, 1'b1, 1'b0, 3, 1, 7, 0);
      corrupt7 = 1'b0;

`ifdef RAM_BIST_ERR_INJECT_EN
      run_test(2'd0, 1'b0, 1'b1, 1, 1, 0, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
